// File: rtl/button_event_classifier.sv
// -----------------------------------------------------------------------------
// button_event_classifier
//
// Turns the debounced centre-button level into one-cycle event pulses:
// single click, double click, long press and auto-repeat while held. The
// registered `step` output (single | long | repeat) replaces the raw press
// pulse as the display counter increment, so holding the button keeps counting.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   button_level  debounced level, synchronous to clk, 1 = pressed
//   single_click  one-cycle pulse: press/release with no second press in time
//   double_click  one-cycle pulse: second press released (not part of step)
//   long_press    one-cycle pulse: button held for LONG_US
//   repeat_tick   one-cycle pulse: every REPEAT_US while held after long_press
//   step          registered single_click | long_press | repeat_tick
//   busy          high whenever the classifier is not idle
// -----------------------------------------------------------------------------
module button_event_classifier #(
  parameter int CLK_PER   = 10,
  parameter int LONG_US   = 500000,
  parameter int DOUBLE_US = 250000,
  parameter int REPEAT_US = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_level,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic repeat_tick,
  output logic step,
  output logic busy
);

  // Microsecond figures are converted in 64-bit arithmetic so large settings
  // do not overflow before the division by the clock period.
  localparam longint LONG_CYC_L   = (longint'(LONG_US)   * 64'sd1000) / longint'(CLK_PER);
  localparam longint DOUBLE_CYC_L = (longint'(DOUBLE_US) * 64'sd1000) / longint'(CLK_PER);
  localparam longint REPEAT_CYC_L = (longint'(REPEAT_US) * 64'sd1000) / longint'(CLK_PER);

  localparam int LONG_CYC   = int'(LONG_CYC_L);
  localparam int DOUBLE_CYC = int'(DOUBLE_CYC_L);
  localparam int REPEAT_CYC = int'(REPEAT_CYC_L);

  localparam int MAX_LD  = (LONG_CYC > DOUBLE_CYC) ? LONG_CYC : DOUBLE_CYC;
  localparam int MAX_CYC = (MAX_LD > REPEAT_CYC) ? MAX_LD : REPEAT_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_CYC - 1);
  localparam logic [TW-1:0] DOUBLE_LAST = TW'(DOUBLE_CYC - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYC - 1);

  // A terminal count below 1 would make a timeout fire on the entry cycle.
  if (LONG_CYC < 2 || DOUBLE_CYC < 2 || REPEAT_CYC < 2) begin : g_bad_cfg
    $error("button_event_classifier: every derived cycle count must be >= 2");
  end

  typedef enum logic [2:0] {
    ARM,     // leaving reset: wait for the button to be released first
    IDLE,
    PRESS1,  // first press, timing towards a long press
    WAIT2,   // released, timing the double-click window
    PRESS2,  // second press, waiting for its release
    HELD     // long press recognised, auto-repeating
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            single_q, single_d;
  logic            double_q, double_d;
  logic            long_q,   long_d;
  logic            repeat_q, repeat_d;
  logic            step_q,   step_d;
  logic            busy_q,   busy_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch. The timer default of 0
    // is also what clears it on each state change.
    state_d  = state_q;
    timer_d  = '0;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;

    unique case (state_q)
      ARM: begin
        if (!button_level) state_d = IDLE;
      end
      IDLE: begin
        if (button_level) state_d = PRESS1;
      end
      PRESS1: begin
        // The timeout is judged on the samples before this edge, so it wins
        // over a release seen on the terminal edge itself.
        if (timer_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = HELD;
        end else if (!button_level) begin
          state_d = WAIT2;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT2: begin
        if (timer_q == DOUBLE_LAST) begin
          single_d = 1'b1;
          state_d  = IDLE;
        end else if (button_level) begin
          state_d = PRESS2;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      PRESS2: begin
        if (!button_level) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end
      end
      HELD: begin
        // Release beats a coincident repeat; a repeat restarts the timer
        // through the default above.
        if (!button_level) begin
          state_d = IDLE;
        end else if (timer_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ARM;
    endcase

    step_d = single_d | long_d | repeat_d;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (reset) begin
      state_q  <= ARM;
      timer_q  <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      step_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
    end
  end

  assign single_click = single_q;
  assign double_click = double_q;
  assign long_press   = long_q;
  assign repeat_tick  = repeat_q;
  assign step         = step_q;
  assign busy         = busy_q;

endmodule
